// File: rtl/data_packet_assembler_pkg.sv
// Shared definitions for the serial packet receive path: field layout, FSM states
// and the DATA PID values also used by the downstream setup stage.
package data_packet_assembler_pkg;

    localparam int PID_W  = 8;
    localparam int DATA_W = 64;
    localparam int CRC_W  = 16;
    localparam int PKT_W  = 89;
    localparam int ASM_W  = PID_W + DATA_W + CRC_W;
    localparam int CNT_W  = 7;

    localparam int PID_MSB  = 87;
    localparam int PID_LSB  = 80;
    localparam int DATA_MSB = 79;
    localparam int DATA_LSB = 16;

    localparam logic [7:0] SYNC_DEFAULT = 8'b0000_0001;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_DATA2 = 8'h87;
    localparam logic [7:0] PID_MDATA = 8'h0F;

    // Last bit_cnt value of each field, and of the tolerated trailing bits after CRC
    localparam logic [CNT_W-1:0] PID_LAST      = 7'd7;
    localparam logic [CNT_W-1:0] DATA_LAST     = 7'd63;
    localparam logic [CNT_W-1:0] CRC_LAST      = 7'd15;
    localparam logic [CNT_W-1:0] OVERLONG_LAST = 7'd31;

    typedef enum logic [2:0] {
        HUNT,
        PID,
        DATA,
        CRC,
        WAIT_EOP
    } state_t;

    function automatic logic pid_malformed(input logic [7:0] pid);
        return pid[7:4] != ~pid[3:0];
    endfunction

endpackage

// File: rtl/data_packet_assembler_if.sv
// Serial receive inputs and assembled-packet outputs of the packet assembler.
interface data_packet_assembler_if;
    import data_packet_assembler_pkg::*;

    logic             rx_bit;
    logic             rx_valid;
    logic             rx_eop;
    logic [PKT_W-1:0] packet;
    logic             packet_valid;
    logic             pid_error;
    logic             frame_error;
    logic             busy;

    modport master (
        output rx_bit, rx_valid, rx_eop,
        input  packet, packet_valid, pid_error, frame_error, busy
    );

    modport slave (
        input  rx_bit, rx_valid, rx_eop,
        output packet, packet_valid, pid_error, frame_error, busy
    );

endinterface

// File: rtl/data_packet_assembler_sync_detector.sv
// Bit-history shift register that flags the cycle in which the sync byte completes.
module data_packet_assembler_sync_detector
    import data_packet_assembler_pkg::*;
#(
    parameter logic [7:0] PATTERN = SYNC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic shift,
    input  logic clear,
    input  logic bit_in,
    output logic sync_hit
);

    // Only the 7 most recent bits are stored; the incoming bit completes the window
    logic [6:0] history;
    logic [7:0] window;

    assign window   = {bit_in, history};
    assign sync_hit = shift && (window == PATTERN);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            history <= '0;
        end else if (shift) begin
            history <= window[7:1];
        end
    end

endmodule

// File: rtl/data_packet_assembler.sv
// Serial-to-parallel packet receiver: hunts for sync, shifts in PID/payload/CRC and
// presents one 89-bit packet word with a single-cycle strobe.
module data_packet_assembler
    import data_packet_assembler_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = SYNC_DEFAULT
) (
    input logic                    clk,
    input logic                    reset,
    data_packet_assembler_if.slave bus
);

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt, cnt_next;
    logic [ASM_W-2:0] asm_reg, asm_next;
    logic [ASM_W-1:0] asm_shift;
    logic             load, abort, sync_hit;

    logic [PKT_W-1:0] packet_reg;
    logic             packet_valid_reg, pid_error_reg, frame_error_reg;

    // The final bit completes the word combinationally, so the store needs one bit less
    assign asm_shift = {asm_reg, bus.rx_bit};

    data_packet_assembler_sync_detector #(.PATTERN(SYNC_PATTERN)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .shift    ((state == HUNT) && bus.rx_valid),
        .clear    (state != HUNT),
        .bit_in   (bus.rx_bit),
        .sync_hit (sync_hit)
    );

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        asm_next   = asm_reg;
        load       = 1'b0;
        abort      = 1'b0;
        case (state)
            HUNT: begin
                if (sync_hit) begin
                    state_next = PID;
                    cnt_next   = '0;
                end
            end
            PID, DATA: begin
                if (bus.rx_eop) begin
                    abort      = 1'b1;
                    state_next = HUNT;
                    cnt_next   = '0;
                end else if (bus.rx_valid) begin
                    asm_next = asm_shift[ASM_W-2:0];
                    if (bit_cnt == ((state == PID) ? PID_LAST : DATA_LAST)) begin
                        state_next = (state == PID) ? DATA : CRC;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = bit_cnt + 7'd1;
                    end
                end
            end
            // An EOP alongside the final CRC bit is a legal exact-length packet
            CRC: begin
                if (bus.rx_valid && (bit_cnt == CRC_LAST)) begin
                    load       = 1'b1;
                    asm_next   = asm_shift[ASM_W-2:0];
                    state_next = bus.rx_eop ? HUNT : WAIT_EOP;
                    cnt_next   = '0;
                end else if (bus.rx_eop) begin
                    abort      = 1'b1;
                    state_next = HUNT;
                    cnt_next   = '0;
                end else if (bus.rx_valid) begin
                    asm_next = asm_shift[ASM_W-2:0];
                    cnt_next = bit_cnt + 7'd1;
                end
            end
            WAIT_EOP: begin
                if (bus.rx_eop) begin
                    state_next = HUNT;
                    cnt_next   = '0;
                end else if (bus.rx_valid) begin
                    if (bit_cnt == OVERLONG_LAST) begin
                        abort      = 1'b1;
                        state_next = HUNT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = bit_cnt + 7'd1;
                    end
                end
            end
            default: begin
                state_next = HUNT;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= HUNT;
            bit_cnt          <= '0;
            asm_reg          <= '0;
            packet_reg       <= '0;
            packet_valid_reg <= 1'b0;
            pid_error_reg    <= 1'b0;
            frame_error_reg  <= 1'b0;
        end else begin
            state            <= state_next;
            bit_cnt          <= cnt_next;
            asm_reg          <= asm_next;
            packet_valid_reg <= load;
            pid_error_reg    <= load && pid_malformed(asm_shift[PID_MSB:PID_LSB]);
            frame_error_reg  <= abort;
            if (load) begin
                packet_reg <= {1'b0, asm_shift};
            end
        end
    end

    assign bus.packet       = packet_reg;
    assign bus.packet_valid = packet_valid_reg;
    assign bus.pid_error    = pid_error_reg;
    assign bus.frame_error  = frame_error_reg;
    assign bus.busy         = (state != HUNT);

endmodule

// File: tb/tb_data_packet_assembler.sv
// Directed-vector bench for data_packet_assembler with hand-computed packet words.
module tb_data_packet_assembler;

    logic clk = 1'b0;
    logic reset;
    logic stallMode;

    int vectorCount = 0;
    int missCount   = 0;
    int pvCount     = 0;
    int feCount     = 0;
    int pvBefore, feBefore;

    localparam logic [63:0] PAYLOAD_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] PAYLOAD_B = 64'hFEDCBA9876543210;
    localparam logic [88:0] CLEAN_PKT = {1'b0, 8'hC3, 64'h0123456789ABCDEF, 16'hBEEF};
    localparam logic [88:0] BADPID_PKT = {1'b0, 8'hC4, 64'h0123456789ABCDEF, 16'hBEEF};
    localparam logic [88:0] NOISE_PKT = {1'b0, 8'h4B, 64'hFEDCBA9876543210, 16'h1234};
    localparam logic [88:0] RESET_PKT = {1'b0, 8'hC3, 64'hFEDCBA9876543210, 16'hCAFE};
    localparam logic [88:0] OVL_PKT = {1'b0, 8'h0F, 64'h0123456789ABCDEF, 16'h0001};

    logic noise [0:19] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};

    always #5 clk = ~clk;

    data_packet_assembler_if bus ();

    data_packet_assembler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.packet_valid) pvCount++;
        if (bus.frame_error) feCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [88:0] observed,
                               input logic [88:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic v, input logic e);
        @(negedge clk);
        bus.rx_bit   = b;
        bus.rx_valid = v;
        bus.rx_eop   = e;
    endtask

    task automatic sendBit(input logic b, input logic e);
        if (stallMode) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        applyStimulus(b, 1'b1, e);
    endtask

    task automatic sendField(input logic [63:0] val, input int width, input int count,
                             input logic eopLast);
        for (int i = 0; i < count; i++) begin
            sendBit(val[width-1-i], eopLast && (i == count - 1));
        end
    endtask

    task automatic sendSync();
        logic [7:0] s;
        s = 8'b0000_0001;
        for (int i = 0; i < 8; i++) sendBit(s[i], 1'b0);
    endtask

    task automatic sendPacket(input logic [7:0] pid, input logic [63:0] payload,
                              input logic [15:0] crc, input logic eopLast);
        sendSync();
        sendField({56'd0, pid}, 8, 8, 1'b0);
        sendField(payload, 64, 64, 1'b0);
        sendField({48'd0, crc}, 16, 16, eopLast);
    endtask

    initial begin
        bus.rx_bit   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_eop   = 1'b0;
        stallMode    = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_packet", bus.packet, '0);
        checkOutput("reset_valid", bus.packet_valid, 0);
        checkOutput("reset_pid_error", bus.pid_error, 0);
        checkOutput("reset_frame_error", bus.frame_error, 0);
        checkOutput("reset_busy", bus.busy, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0);

        // clean packet, strobe exactly one cycle after the last CRC bit
        sendPacket(8'hC3, PAYLOAD_A, 16'hBEEF, 1'b0);
        checkOutput("clean_valid_early", bus.packet_valid, 0);
        applyStimulus(0, 0, 0);
        checkOutput("clean_valid", bus.packet_valid, 1);
        checkOutput("clean_packet", bus.packet, CLEAN_PKT);
        checkOutput("clean_pid_error", bus.pid_error, 0);
        checkOutput("clean_frame_error", bus.frame_error, 0);
        checkOutput("clean_busy_wait_eop", bus.busy, 1);
        applyStimulus(0, 0, 0);
        checkOutput("clean_valid_drop", bus.packet_valid, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        checkOutput("clean_busy_after_eop", bus.busy, 0);
        checkOutput("clean_no_frame_error", bus.frame_error, 0);

        // malformed PID
        sendPacket(8'hC4, PAYLOAD_A, 16'hBEEF, 1'b0);
        applyStimulus(0, 0, 0);
        checkOutput("badpid_valid", bus.packet_valid, 1);
        checkOutput("badpid_pid_error", bus.pid_error, 1);
        checkOutput("badpid_packet", bus.packet, BADPID_PKT);
        applyStimulus(0, 0, 1);

        // early EOP after 40 payload bits, with a simultaneous valid bit
        sendSync();
        sendField({56'd0, 8'hC3}, 8, 8, 1'b0);
        sendField(PAYLOAD_A, 64, 40, 1'b0);
        applyStimulus(1, 1, 1);
        applyStimulus(0, 0, 0);
        checkOutput("early_frame_error", bus.frame_error, 1);
        checkOutput("early_valid", bus.packet_valid, 0);
        checkOutput("early_busy", bus.busy, 0);
        checkOutput("early_packet_kept", bus.packet, BADPID_PKT);
        applyStimulus(0, 0, 0);
        checkOutput("early_frame_error_pulse", bus.frame_error, 0);

        // rx_valid high one cycle in three
        #1 pvBefore = pvCount;
        stallMode = 1'b1;
        sendPacket(8'hC3, PAYLOAD_A, 16'hBEEF, 1'b0);
        stallMode = 1'b0;
        applyStimulus(0, 0, 0);
        checkOutput("stall_valid", bus.packet_valid, 1);
        checkOutput("stall_packet", bus.packet, CLEAN_PKT);
        applyStimulus(0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0);
        #1 checkOutput("stall_pulse_count", 89'(pvCount - pvBefore), 1);

        // noise without a sync window, then an exact-length packet
        for (int i = 0; i < 20; i++) sendBit(noise[i], 1'b0);
        applyStimulus(0, 0, 0);
        checkOutput("noise_busy", bus.busy, 0);
        sendPacket(8'h4B, PAYLOAD_B, 16'h1234, 1'b1);
        applyStimulus(0, 0, 0);
        checkOutput("noise_valid", bus.packet_valid, 1);
        checkOutput("noise_packet", bus.packet, NOISE_PKT);
        checkOutput("exact_eop_busy", bus.busy, 0);
        checkOutput("exact_eop_frame_error", bus.frame_error, 0);

        // reset in the middle of the payload
        #1 feBefore = feCount;
        sendSync();
        sendField({56'd0, 8'hC3}, 8, 8, 1'b0);
        sendField(PAYLOAD_A, 64, 30, 1'b0);
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset_packet", bus.packet, '0);
        checkOutput("midreset_valid", bus.packet_valid, 0);
        checkOutput("midreset_frame_error", bus.frame_error, 0);
        checkOutput("midreset_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) applyStimulus(0, 0, 0);
        #1 checkOutput("midreset_no_error_pulse", 89'(feCount - feBefore), 0);
        sendPacket(8'hC3, PAYLOAD_B, 16'hCAFE, 1'b0);
        applyStimulus(0, 0, 0);
        checkOutput("postreset_valid", bus.packet_valid, 1);
        checkOutput("postreset_packet", bus.packet, RESET_PKT);
        applyStimulus(0, 0, 1);

        // overlong tail: the 32nd trailing bit aborts, the packet stands
        sendPacket(8'h0F, PAYLOAD_A, 16'h0001, 1'b0);
        applyStimulus(0, 0, 0);
        checkOutput("ovl_valid", bus.packet_valid, 1);
        for (int i = 0; i < 31; i++) sendBit(1'b1, 1'b0);
        applyStimulus(1, 1, 0);
        checkOutput("ovl_31_frame_error", bus.frame_error, 0);
        checkOutput("ovl_31_busy", bus.busy, 1);
        applyStimulus(0, 0, 0);
        checkOutput("ovl_32_frame_error", bus.frame_error, 1);
        checkOutput("ovl_32_busy", bus.busy, 0);
        checkOutput("ovl_packet_kept", bus.packet, OVL_PKT);
        applyStimulus(0, 0, 0);
        checkOutput("ovl_frame_error_pulse", bus.frame_error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
